// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends one shared up-counter.
// A granted requester watches A run 0..len, then receives a one-cycle
// done pulse; a one-cycle gap follows before the next arbitration.
module counter_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] A,
   output logic             done0,
   output logic             done1,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_a,     w_a;
   logic [WIDTH-1:0] r_len,   w_len;
   logic             r_gnt0,  w_gnt0;
   logic             r_gnt1,  w_gnt1;
   logic             r_done0, w_done0;
   logic             r_done1, w_done1;
   logic             r_busy,  w_busy;
   // last-served pointer: 0 = requester 0, 1 = requester 1
   logic             r_ptr,   w_ptr;
   logic             w_sel;

   // next-state and next-output computation; every output is a flop
   always_comb begin
      w_state = r_state;
      w_a     = r_a;
      w_len   = r_len;
      w_gnt0  = r_gnt0;
      w_gnt1  = r_gnt1;
      w_done0 = 1'b0;
      w_done1 = 1'b0;
      w_ptr   = r_ptr;
      w_sel   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req0 || req1) begin
               // on a tie, the requester not served last wins
               w_sel   = (req0 && req1) ? ~r_ptr : req1;
               w_state = S_COUNT;
               w_gnt0  = ~w_sel;
               w_gnt1  = w_sel;
               w_len   = w_sel ? len1 : len0;
               w_a     = '0;
            end
         end
         S_COUNT: begin
            if (r_a == r_len) begin
               w_state = S_DONE;
               w_gnt0  = 1'b0;
               w_gnt1  = 1'b0;
               w_done0 = r_gnt0;
               w_done1 = r_gnt1;
               w_a     = '0;
               w_ptr   = r_gnt1;
            end else begin
               w_a = r_a + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            // unconditional gap cycle before the next arbitration
            w_state = S_IDLE;
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
         end
         default: begin
            w_state = S_IDLE;
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
            w_a     = '0;
         end
      endcase
      w_busy = (w_state != S_IDLE);
   end

   // state register; reset aborts any run without a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_len   <= '0;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_busy  <= 1'b0;
         r_ptr   <= 1'b1;
      end else begin
         r_state <= w_state;
         r_a     <= w_a;
         r_len   <= w_len;
         r_gnt0  <= w_gnt0;
         r_gnt1  <= w_gnt1;
         r_done0 <= w_done0;
         r_done1 <= w_done1;
         r_busy  <= w_busy;
         r_ptr   <= w_ptr;
      end
   end

   assign gnt0  = r_gnt0;
   assign gnt1  = r_gnt1;
   assign A     = r_a;
   assign done0 = r_done0;
   assign done1 = r_done1;
   assign busy  = r_busy;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a run-level model expands each grant into the
// full expected output sequence, checked every cycle, plus literal pins.
module tb_counter_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0, req1;
   logic [W-1:0] len0, len1;
   logic         gnt0, gnt1, done0, done1, busy;
   logic [W-1:0] A;

   typedef struct packed {
      logic         gnt0;
      logic         gnt1;
      logic [W-1:0] a;
      logic         done0;
      logic         done1;
      logic         busy;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   logic ptr;
   int   checks   = 0;
   int   failures = 0;
   int   cyc_n    = 0;

   counter_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .len0(len0), .req1(req1), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .A(A),
      .done0(done0), .done1(done1), .busy(busy)
   );

   always #5 clk = ~clk;

   // expand one granted run into its cycle-by-cycle outputs
   task automatic push_run(input logic who, input logic [W-1:0] l);
      exp_t e;
      for (int i = 0; i <= int'(l); i++) begin
         e = '0;
         e.gnt0 = ~who;
         e.gnt1 = who;
         e.a    = W'(i);
         e.busy = 1'b1;
         q.push_back(e);
      end
      e = '0;
      e.done0 = ~who;
      e.done1 = who;
      e.busy  = 1'b1;
      q.push_back(e);
      e = '0;
      q.push_back(e);
   endtask

   // model reaction to the inputs seen at a rising edge
   task automatic model_step();
      logic win;
      if (reset) begin
         q.delete();
         ptr = 1'b1;
         cur = '0;
      end else begin
         if (q.size() == 0 && (req0 || req1)) begin
            if (req0 && req1) win = (ptr == 1'b1) ? 1'b0 : 1'b1;
            else              win = req1;
            push_run(win, win ? len1 : len0);
         end
         if (q.size() != 0) cur = q.pop_front();
         else               cur = '0;
         if (cur.done0) ptr = 1'b0;
         if (cur.done1) ptr = 1'b1;
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, got, exp);
      end
   endtask

   // one clock: model at the edge, compare at the falling edge
   task automatic cyc();
      exp_t d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_n++;
      d = {gnt0, gnt1, A, done0, done1, busy};
      chk("model", int'(d), int'(cur));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         cyc();
         n++;
      end
      chk("idle_timeout", q.size(), 0);
   endtask

   initial begin
      ptr   = 1'b1;
      cur   = '0;
      reset = 1'b1;
      req0  = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;

      // reset with random request traffic: outputs all zero
      for (int i = 0; i < 3; i++) begin
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         len0 = W'($urandom);
         len1 = W'($urandom);
         cyc();
         chk("reset_outs", int'({gnt0, gnt1, A, done0, done1, busy}), 0);
      end
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      cyc();

      // single run, len0=3; req drop and len change after grant ignored
      req0 = 1'b1; len0 = 4'd3;
      cyc();
      chk("r0_first_gnt", int'({gnt0, gnt1, A, busy}), 'b10_0000_1);
      req0 = 1'b0; len0 = 4'd1;
      cyc(); cyc(); cyc();
      chk("r0_A3", int'({gnt0, A}), 'b1_0011);
      cyc();
      chk("r0_done", int'({gnt0, done0, done1, A, busy}), 'b010_0000_1);
      cyc();
      chk("r0_idle", int'({gnt0, gnt1, done0, busy}), 0);

      // len=0 run on requester 1
      req1 = 1'b1; len1 = 4'd0;
      cyc();
      chk("r1_len0_gnt", int'({gnt1, A}), 'b1_0000);
      req1 = 1'b0;
      cyc();
      chk("r1_len0_done", int'({gnt1, done1}), 'b01);
      wait_idle();

      // reset, then held tie: 0, then 1, then 0 again
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
      cyc();
      chk("tie1_gnt0", int'({gnt0, gnt1}), 'b10);
      cyc(); cyc(); cyc();
      chk("tie1_done0", int'({done0, done1, gnt0}), 'b100);
      cyc(); cyc();
      chk("tie2_gnt1", int'({gnt0, gnt1, A}), 'b01_0000);
      cyc(); cyc(); cyc(); cyc(); cyc();
      chk("tie3_gnt0", int'({gnt0, gnt1}), 'b10);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      // full-scale length: 16 gnt cycles, no wrap
      req0 = 1'b1; len0 = 4'd15;
      cyc();
      req0 = 1'b0;
      for (int i = 0; i < 15; i++) cyc();
      chk("max_A15", int'({gnt0, A}), 'b1_1111);
      cyc();
      chk("max_done", int'({gnt0, done0, A}), 'b01_0000);
      wait_idle();

      // reset mid-run at A=5: no done, pointer back to requester 1
      req0 = 1'b1; len0 = 4'd10;
      cyc();
      req0 = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk("abort_A5", int'({gnt0, A}), 'b1_0101);
      reset = 1'b1;
      cyc();
      chk("abort_outs", int'({gnt0, gnt1, A, done0, done1, busy}), 0);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd1;
      cyc();
      chk("abort_tie_gnt0", int'({gnt0, gnt1, done0}), 'b100);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
